// File: rtl/adc_capture_if.sv
// Sample delivery bus of adc_capture: one 12-bit sample plus its channel,
// handed over with a valid/ready handshake.
interface adc_capture_if;
   logic [11:0] sample;
   logic [2:0]  sample_chan;
   logic        sample_valid;
   logic        sample_ready;

   modport master (
      output sample,
      output sample_chan,
      output sample_valid,
      input  sample_ready
   );

   modport slave (
      input  sample,
      input  sample_chan,
      input  sample_valid,
      output sample_ready
   );
endinterface

// File: rtl/adc_capture.sv
// Serial front end for an 8-channel 12-bit SPI ADC: periodic 16-slot frames,
// one-deep valid/ready output register with sticky overrun flag.
module adc_capture #(
   parameter int unsigned CLK_DIV    = 16,
   parameter int unsigned SAMPLE_DIV = 6250
) (
   input  logic          CLOCK_50,
   input  logic          RESET,
   input  logic          enable,
   input  logic [2:0]    channel,
   output logic          ADC_CS_N,
   output logic          ADC_CLK,
   output logic          ADC_OUT,
   input  logic          ADC_IN,
   adc_capture_if.master smp,
   output logic          overrun
);

   localparam int unsigned PH_W   = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
   localparam int unsigned RATE_W = $clog2(SAMPLE_DIV);
   localparam int unsigned HALF   = CLK_DIV / 2;

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] SHIFT = 2'd1;
   localparam logic [1:0] DONE  = 2'd2;

   logic [1:0]        state;
   logic [1:0]        state_nxt;
   logic [RATE_W-1:0] rate_cnt;
   logic [PH_W-1:0]   ph;
   logic [3:0]        bit_cnt;
   logic [2:0]        cur_chan;
   logic [2:0]        stage_chan;
   logic [2:0]        prev_chan;
   logic [11:0]       shreg;
   logic [15:0]       cmd_c;
   logic              start_c;
   logic              fall_c;
   logic              rise_c;

   assign cmd_c = {2'b00, cur_chan, 11'b0};

   // Sample-rate counter; parked at zero while disabled so the first frame
   // starts right after enable rises.
   always_ff @(posedge CLOCK_50) begin
      if (RESET) begin
         rate_cnt <= '0;
      end else if (!enable) begin
         rate_cnt <= '0;
      end else if (rate_cnt == RATE_W'(SAMPLE_DIV - 1)) begin
         rate_cnt <= '0;
      end else begin
         rate_cnt <= rate_cnt + RATE_W'(1);
      end
   end

   always_ff @(posedge CLOCK_50) begin
      if (RESET) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state and ADC_CLK edge strobes within a bit slot.
   always_comb begin
      state_nxt = state;
      start_c   = 1'b0;
      fall_c    = 1'b0;
      rise_c    = 1'b0;
      case (state)
         IDLE: begin
            if (enable && (rate_cnt == '0)) begin
               start_c   = 1'b1;
               state_nxt = SHIFT;
            end
         end
         SHIFT: begin
            fall_c = (ph == PH_W'(HALF - 1));
            rise_c = (ph == PH_W'(CLK_DIV - 1));
            if (rise_c && (bit_cnt == 4'd15)) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Serial engine: command out on falling edges, data in on rising edges.
   // Only the low 12 of the 16 shifted-in bits are ever used, so only those are kept.
   always_ff @(posedge CLOCK_50) begin
      if (RESET) begin
         ADC_CS_N   <= 1'b1;
         ADC_CLK    <= 1'b1;
         ADC_OUT    <= 1'b0;
         ph         <= '0;
         bit_cnt    <= '0;
         cur_chan   <= '0;
         stage_chan <= '0;
         prev_chan  <= '0;
         shreg      <= '0;
      end else begin
         if (start_c) begin
            cur_chan   <= channel;
            stage_chan <= prev_chan;
            ADC_CS_N   <= 1'b0;
            ADC_OUT    <= 1'b0;
            ph         <= '0;
            bit_cnt    <= '0;
         end
         if (state == SHIFT) begin
            ph <= rise_c ? '0 : ph + PH_W'(1);
            if (fall_c) begin
               ADC_CLK <= 1'b0;
               ADC_OUT <= cmd_c[4'hF - bit_cnt];
            end
            if (rise_c) begin
               ADC_CLK <= 1'b1;
               shreg   <= {shreg[10:0], ADC_IN};
               bit_cnt <= bit_cnt + 4'd1;
            end
         end
         if (state == DONE) begin
            ADC_CS_N  <= 1'b1;
            prev_chan <= cur_chan;
         end
      end
   end

   // Output register; a disabled block always clears the sticky overrun.
   always_ff @(posedge CLOCK_50) begin
      if (RESET) begin
         smp.sample       <= '0;
         smp.sample_chan  <= '0;
         smp.sample_valid <= 1'b0;
         overrun          <= 1'b0;
      end else begin
         if (state == DONE) begin
            smp.sample       <= shreg;
            smp.sample_chan  <= stage_chan;
            smp.sample_valid <= 1'b1;
            if (smp.sample_valid && !smp.sample_ready) begin
               overrun <= 1'b1;
            end
         end else if (smp.sample_valid && smp.sample_ready) begin
            smp.sample_valid <= 1'b0;
         end
         if (!enable) begin
            overrun <= 1'b0;
         end
      end
   end

endmodule

// File: doc/adc_capture.md
# adc_capture

Serial front end for the on-board 8-channel, 12-bit SPI ADC, driving `ADC_CS_N`/`ADC_CLK`/`ADC_OUT` and reading `ADC_IN`. It runs periodic conversion frames at a fixed sample rate on a selectable channel. Each frame delivers one 12-bit sample through a one-deep valid/ready output register. It sits directly under the recorder top level and feeds the sample path that goes to SDRAM.

## Interface
- `CLK_DIV`, 16: system clocks per `ADC_CLK` period; even, ≥4. 50 MHz/16 gives 3.125 MHz.
- `SAMPLE_DIV`, 6250: system clocks between frame starts; ≥ 16*`CLK_DIV`+2. 6250 gives 8 kHz.
- `CLOCK_50`  in  1  system clock; all logic is on its rising edge.
- `RESET`  in  1  synchronous, active-high reset.
- `enable`  in  1  run periodic conversions.
- `channel`  in  3  ADC address, latched at frame start.
- `ADC_CS_N`  out  1  ADC chip select, active low.
- `ADC_CLK`  out  1  ADC serial clock; idles high.
- `ADC_OUT`  out  1  command bits to the ADC's DIN pin.
- `ADC_IN`  in  1  data bits from the ADC's DOUT pin.
- `sample`  out  12  converted value.
- `sample_chan`  out  3  channel that `sample` belongs to.
- `sample_valid`  out  1  `sample` is held and pending.
- `sample_ready`  in  1  consumer accepts `sample` this cycle.
- `overrun`  out  1  sticky: an unaccepted sample was overwritten.

## Operation
- Reset values:
  - `ADC_CS_N`=1, `ADC_CLK`=1, `ADC_OUT`=0.
  - `sample`=0, `sample_chan`=0, `sample_valid`=0, `overrun`=0.
  - State IDLE, rate counter 0, `prev_chan`=0.
- Rate counter:
  - Held at 0 while `enable`=0.
  - Otherwise counts 0..`SAMPLE_DIV`-1 and wraps.
  - A frame starts when the counter is 0, `enable`=1 and the state is IDLE.
- States:
  - IDLE → SHIFT on frame start.
  - SHIFT runs 16 bit slots.
  - SHIFT → DONE after the 16th rising edge of `ADC_CLK`.
  - DONE → IDLE after one cycle.
- At frame start:
  - Latch `channel` into `cur_chan`.
  - Latch `prev_chan` into the output-channel staging register.
  - The ADC returns the channel addressed in the previous frame.
- Command word, MSB first: {2'b00, `cur_chan`, 11'b0}.
  - `ADC_OUT` changes only on `ADC_CLK` falling edges.
  - `ADC_OUT` is 0 before the first falling edge.
- Data word: `ADC_IN` is sampled into a 16-bit shift register on each rising edge of `ADC_CLK`. `sample` takes the shift register's bits[11:0]; bits[15:12] are ignored.
- DONE:
  - `ADC_CS_N`=1.
  - `prev_chan` ← `cur_chan`.
  - The new sample is loaded into the output register.
- Output register:
  - Load sets `sample_valid`=1.
  - `sample_valid` && `sample_ready` with no load in that cycle clears `sample_valid`.
  - Load with `sample_valid`=1 and `sample_ready`=0: overwrite and set `overrun`.
  - Load with `sample_valid`=1 and `sample_ready`=1: load, `sample_valid` stays 1, no overrun.
- `overrun` clears only on `RESET` or while `enable`=0.
- `enable` falling mid-frame: the frame completes and its sample is delivered, then the block stays IDLE.
- `RESET` mid-frame: all registers return to reset values on the next edge. The partial frame is discarded and no `sample_valid` is produced.

## Timing
- Let H=`CLK_DIV`/2 and T0 = first cycle with `ADC_CS_N`=0.
- Bit slot k=0..15:
  - `ADC_CLK` falls at T0+H+k*`CLK_DIV`.
  - `ADC_CLK` rises at T0+(k+1)*`CLK_DIV`.
- `ADC_IN` is captured by the same edge that drives `ADC_CLK` high, i.e. it is the value present during the low phase.
- Address bits `cur_chan`[2:0] are driven in slots k=2,3,4.
- The last rising edge is at T0+16*`CLK_DIV`.
- At T0+16*`CLK_DIV`+1: `ADC_CS_N`=1 and `sample_valid`=1.
- Conversion latency from `ADC_CS_N` falling to valid: 16*`CLK_DIV`+1 cycles.
- Frame period is exactly `SAMPLE_DIV` cycles.
- With `enable` high, the first frame starts the cycle after `enable` rises.
- `ADC_CS_N` high time between frames is `SAMPLE_DIV`-16*`CLK_DIV`-1 cycles, at least 1.

## Test plan
All cases use `CLK_DIV`=4, `SAMPLE_DIV`=80 and an ADC model that shifts 4 zeros followed by 12 data bits on falling edges.

- **Basic frame:** model value 12'hA5C, `channel`=3, `sample_ready`=1 → `ADC_CS_N` low for 65 cycles, 16 `ADC_CLK` pulses, `sample_valid` at T0+65 with `sample`=12'hA5C and `sample_chan`=0. Model decodes address 3.
- **Channel pipeline:** frames with `channel` 3, 5, 7 → `sample_chan` sequence 0, 3, 5. Frame starts are 80 cycles apart.
- **Backpressure:** hold `sample_ready`=0 for two frames → first sample held, overwritten by the second, `overrun`=1. Then `sample_ready`=1 → `sample_valid` drops next cycle and `overrun` stays 1.
- **Simultaneous accept and load:** `sample_ready` pulsed in the exact DONE cycle → new sample loaded, `sample_valid` stays 1, `overrun`=0.
- **Enable drop:** `enable` low at T0+20 → frame completes, valid at T0+65, no further `ADC_CS_N` activity, and `overrun` clears.
- **Reset mid-frame:** `RESET` at T0+30 → next cycle `ADC_CS_N`=1, `ADC_CLK`=1, `sample_valid`=0. A fresh frame starts on the first non-reset cycle with `enable`=1.
